mem_port_arbiter: RTL and testbench

//  Shares the single 32-bit block-wide data memory between the instruction cache and the data cache.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the icache, dcache and memory-side handshakes of the shared memory port.
// The arbiter is the bus master toward memory; the caches and memory model sit on the slave side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic              i_read;
   logic [ADDR_W-1:0] i_address;
   logic [DATA_W-1:0] i_readdata;
   logic              i_busywait;

   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_address;
   logic [DATA_W-1:0] d_writedata;
   logic [DATA_W-1:0] d_readdata;
   logic              d_busywait;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_writedata;
   logic [DATA_W-1:0] mem_readdata;
   logic              mem_busywait;

   modport master (
      input  i_read, i_address, d_read, d_write, d_address, d_writedata,
      input  mem_readdata, mem_busywait,
      output i_readdata, i_busywait, d_readdata, d_busywait,
      output mem_read, mem_write, mem_address, mem_writedata
   );

   modport slave (
      output i_read, i_address, d_read, d_write, d_address, d_writedata,
      output mem_readdata, mem_busywait,
      input  i_readdata, i_busywait, d_readdata, d_busywait,
      input  mem_read, mem_write, mem_address, mem_writedata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one block-wide data memory between the icache and dcache,
// with a registered memory request and a sticky watchdog for a memory that never completes.
module mem_port_arbiter #(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 32,
   parameter int TIMEOUT    = 255,
   parameter bit RESET_PRIO = 1'b1
) (
   input  logic                clock,
   input  logic                reset,
   mem_port_arbiter_if.master  bus,
   output logic                timeout_err
);
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic {GRANT_I = 1'b0, GRANT_D = 1'b1} grant_t;

   state_t          state;
   grant_t          winner;
   grant_t          last_grant;
   grant_t          pick;
   logic            seen;
   logic [WD_W-1:0] watchdog;
   logic [WD_W-1:0] watchdog_nxt;
   logic            i_req;
   logic            d_req;

   assign i_req        = bus.i_read;
   assign d_req        = bus.d_read | bus.d_write;
   assign watchdog_nxt = watchdog + 1'b1;

   // Stall drops only for the winner during its single DONE cycle.
   assign bus.i_busywait = i_req && !(state == DONE && winner == GRANT_I);
   assign bus.d_busywait = d_req && !(state == DONE && winner == GRANT_D);

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      pick = GRANT_I;
      if (i_req && d_req)
         pick = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
      else if (d_req)
         pick = GRANT_D;
   end

   // NOTE: sequential state uses non-blocking assignments only; every register, including the
   // data-holding readdata/mem_* registers, is cleared by the asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         winner            <= GRANT_I;
         last_grant        <= RESET_PRIO ? GRANT_I : GRANT_D;
         seen              <= 1'b0;
         watchdog          <= '0;
         timeout_err       <= 1'b0;
         bus.mem_read      <= 1'b0;
         bus.mem_write     <= 1'b0;
         bus.mem_address   <= '0;
         bus.mem_writedata <= '0;
         bus.i_readdata    <= '0;
         bus.d_readdata    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  winner <= pick;
                  if (pick == GRANT_D) begin
                     bus.mem_address   <= bus.d_address;
                     bus.mem_writedata <= bus.d_writedata;
                     bus.mem_write     <= bus.d_write;
                     bus.mem_read      <= !bus.d_write;
                  end else begin
                     bus.mem_address   <= bus.i_address;
                     bus.mem_write     <= 1'b0;
                     bus.mem_read      <= 1'b1;
                  end
                  seen     <= 1'b0;
                  watchdog <= '0;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               watchdog <= watchdog_nxt;
               if (bus.mem_busywait)
                  seen <= 1'b1;
               // A completion seen on the same edge the watchdog expires still wins.
               if (seen && !bus.mem_busywait) begin
                  if (bus.mem_read) begin
                     if (winner == GRANT_D)
                        bus.d_readdata <= bus.mem_readdata;
                     else
                        bus.i_readdata <= bus.mem_readdata;
                  end
                  bus.mem_read  <= 1'b0;
                  bus.mem_write <= 1'b0;
                  state         <= DONE;
               end else if (watchdog_nxt == WD_MAX) begin
                  timeout_err   <= 1'b1;
                  bus.mem_read  <= 1'b0;
                  bus.mem_write <= 1'b0;
                  state         <= DONE;
               end
            end
            DONE: begin
               last_grant <= winner;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction table plus hand sequences for
// contention, round-robin, write-back, watchdog expiry and reset during an access.
module tb_mem_port_arbiter;
   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;

   logic clock = 1'b0;
   logic reset;
   logic timeout_err;
   int   n_applied     = 0;
   int   n_miscompares = 0;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8), .RESET_PRIO(1'b1)
   ) dut (
      .clock(clock), .reset(reset), .bus(bus), .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   // Memory model: busy for mem_busy_cycles cycles of an active strobe, or forever when stuck.
   int          mem_cnt = 0;
   int          mem_busy_cycles = 5;
   bit          mem_stuck = 1'b0;
   logic [5:0]  wr_addr_seen = '0;
   logic [31:0] wr_data_seen = '0;

   assign bus.mem_busywait = mem_stuck || ((bus.mem_read || bus.mem_write) && (mem_cnt < mem_busy_cycles));
   assign bus.mem_readdata = (bus.mem_address == 6'h05) ? 32'hDEADBEEF
                                                        : (32'h5A000000 | {26'd0, bus.mem_address});

   always @(posedge clock) begin
      if (bus.mem_read || bus.mem_write) mem_cnt <= mem_cnt + 1;
      else mem_cnt <= 0;
      if (bus.mem_write && !bus.mem_busywait) begin
         wr_addr_seen <= bus.mem_address;
         wr_data_seen <= bus.mem_writedata;
      end
   end

   bit mon_en = 1'b0;
   bit d_bw_seen;
   always @(negedge clock) d_bw_seen <= mon_en ? (d_bw_seen | bus.d_busywait) : 1'b0;

   typedef struct {
      logic        ir;
      logic [5:0]  ia;
      logic        dr;
      logic        dw;
      logic [5:0]  da;
      logic [31:0] dwd;
      int          busy;
      logic        exp_d;
      logic [5:0]  exp_addr;
      logic        exp_rd;
      logic        exp_wr;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t        vecs[7];
   logic [31:0] exp_i_rd = '0;
   logic [31:0] exp_d_rd = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [5:0] ia, input logic dr, input logic dw,
                        input logic [5:0] da, input logic [31:0] dwd);
      bus.i_read      = ir;
      bus.i_address   = ia;
      bus.d_read      = dr;
      bus.d_write     = dw;
      bus.d_address   = da;
      bus.d_writedata = dwd;
   endtask

   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clock);
         if (bus.mem_read || bus.mem_write) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(input bit is_d, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clock);
         if ((is_d ? bus.d_busywait : bus.i_busywait) == 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit          ok;
      bit          held;
      int          cnt;
      logic [5:0]  rr_exp [4];

      vecs[0] = '{1'b0, 6'h00, 1'b1, 1'b0, 6'h10, 32'h0,        2, 1'b1, 6'h10, 1'b1, 1'b0, 32'h0,        32'h5A000010};
      vecs[1] = '{1'b0, 6'h00, 1'b0, 1'b1, 6'h3A, 32'h12345678, 3, 1'b1, 6'h3A, 1'b0, 1'b1, 32'h12345678, 32'h0};
      vecs[2] = '{1'b1, 6'h20, 1'b0, 1'b0, 6'h00, 32'h0,        1, 1'b0, 6'h20, 1'b1, 1'b0, 32'h0,        32'h5A000020};
      vecs[3] = '{1'b1, 6'h07, 1'b1, 1'b0, 6'h08, 32'h0,        2, 1'b1, 6'h08, 1'b1, 1'b0, 32'h0,        32'h5A000008};
      vecs[4] = '{1'b1, 6'h09, 1'b0, 1'b1, 6'h0A, 32'hCAFEF00D, 2, 1'b0, 6'h09, 1'b1, 1'b0, 32'h0,        32'h5A000009};
      vecs[5] = '{1'b0, 6'h00, 1'b1, 1'b1, 6'h11, 32'h0BADF00D, 1, 1'b1, 6'h11, 1'b0, 1'b1, 32'h0BADF00D, 32'h0};
      vecs[6] = '{1'b1, 6'h30, 1'b0, 1'b0, 6'h00, 32'h0,        3, 1'b0, 6'h30, 1'b1, 1'b0, 32'h0,        32'h5A000030};
      rr_exp  = '{6'h22, 6'h21, 6'h22, 6'h21};

      // Reset state
      reset = 1'b1;
      drive(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 32'h0);
      repeat (2) @(negedge clock);
      check("reset strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
      check("reset timeout_err", {31'd0, timeout_err}, 32'd0);
      check("reset mem_address", {26'd0, bus.mem_address}, 32'd0);
      check("reset i_readdata", bus.i_readdata, 32'd0);
      check("reset d_readdata", bus.d_readdata, 32'd0);
      reset = 1'b0;

      // Simultaneous first request after reset: dcache first, then icache
      mem_busy_cycles = 3;
      @(negedge clock);
      drive(1'b1, 6'h01, 1'b1, 1'b0, 6'h02, 32'h0);
      wait_grant(ok);
      check("simul grant1", {31'd0, ok}, 32'd1);
      check("simul addr1", {26'd0, bus.mem_address}, 32'h02);
      wait_done(1'b1, ok);
      check("simul done1", {31'd0, ok}, 32'd1);
      check("simul d_readdata", bus.d_readdata, 32'h5A000002);
      check("simul i stalled", {31'd0, bus.i_busywait}, 32'd1);
      bus.d_read = 1'b0;
      wait_grant(ok);
      check("simul addr2", {26'd0, bus.mem_address}, 32'h01);
      wait_done(1'b0, ok);
      check("simul done2", {31'd0, ok}, 32'd1);
      check("simul i_readdata", bus.i_readdata, 32'h5A000001);
      check("simul d untouched", bus.d_readdata, 32'h5A000002);
      drive(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 32'h0);
      exp_i_rd = 32'h5A000001;
      exp_d_rd = 32'h5A000002;

      // Lone icache read, memory busy 5 cycles
      mem_busy_cycles = 5;
      @(negedge clock);
      mon_en = 1'b1;
      drive(1'b1, 6'h05, 1'b0, 1'b0, 6'h00, 32'h0);
      #1;
      check("lone busywait rise", {31'd0, bus.i_busywait}, 32'd1);
      wait_grant(ok);
      check("lone grant", {31'd0, ok}, 32'd1);
      check("lone strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'b10);
      check("lone addr", {26'd0, bus.mem_address}, 32'h05);
      wait_done(1'b0, ok);
      check("lone done", {31'd0, ok}, 32'd1);
      check("lone i_readdata", bus.i_readdata, 32'hDEADBEEF);
      @(negedge clock);
      check("lone busywait 1 cycle", {31'd0, bus.i_busywait}, 32'd1);
      bus.i_read = 1'b0;
      check("lone d_busywait quiet", {31'd0, d_bw_seen}, 32'd0);
      mon_en = 1'b0;
      exp_i_rd = 32'hDEADBEEF;

      // Transaction table
      foreach (vecs[k]) begin
         mem_busy_cycles = vecs[k].busy;
         @(negedge clock);
         drive(vecs[k].ir, vecs[k].ia, vecs[k].dr, vecs[k].dw, vecs[k].da, vecs[k].dwd);
         wait_grant(ok);
         check($sformatf("v%0d grant", k), {31'd0, ok}, 32'd1);
         check($sformatf("v%0d addr", k), {26'd0, bus.mem_address}, {26'd0, vecs[k].exp_addr});
         check($sformatf("v%0d op", k), {30'd0, bus.mem_read, bus.mem_write},
               {30'd0, vecs[k].exp_rd, vecs[k].exp_wr});
         if (vecs[k].exp_wr)
            check($sformatf("v%0d wdata", k), bus.mem_writedata, vecs[k].exp_wdata);
         wait_done(vecs[k].exp_d, ok);
         check($sformatf("v%0d done", k), {31'd0, ok}, 32'd1);
         if (vecs[k].exp_rd) begin
            if (vecs[k].exp_d) exp_d_rd = vecs[k].exp_rdata;
            else exp_i_rd = vecs[k].exp_rdata;
         end
         check($sformatf("v%0d i_readdata", k), bus.i_readdata, exp_i_rd);
         check($sformatf("v%0d d_readdata", k), bus.d_readdata, exp_d_rd);
         drive(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 32'h0);
      end

      // Round-robin with both requesters held for 4 transactions
      mem_busy_cycles = 2;
      @(negedge clock);
      drive(1'b1, 6'h21, 1'b1, 1'b0, 6'h22, 32'h0);
      for (int t = 0; t < 4; t++) begin
         wait_grant(ok);
         check($sformatf("rr%0d grant", t), {31'd0, ok}, 32'd1);
         check($sformatf("rr%0d addr", t), {26'd0, bus.mem_address}, {26'd0, rr_exp[t]});
         wait_done(t % 2 == 0, ok);
         check($sformatf("rr%0d done", t), {31'd0, ok}, 32'd1);
      end
      drive(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 32'h0);
      exp_i_rd = 32'h5A000021;
      exp_d_rd = 32'h5A000022;
      check("rr i_readdata", bus.i_readdata, exp_i_rd);
      check("rr d_readdata", bus.d_readdata, exp_d_rd);

      // Write-back: request held constant through ACCESS
      mem_busy_cycles = 4;
      @(negedge clock);
      drive(1'b0, 6'h00, 1'b0, 1'b1, 6'h3A, 32'h12345678);
      wait_grant(ok);
      check("wb grant", {31'd0, ok}, 32'd1);
      held = 1'b1;
      ok   = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (!(bus.mem_write === 1'b1 && bus.mem_read === 1'b0 && bus.mem_address === 6'h3A &&
               bus.mem_writedata === 32'h12345678)) held = 1'b0;
         @(negedge clock);
         if (!bus.d_busywait) begin
            ok = 1'b1;
            break;
         end
      end
      check("wb done", {31'd0, ok}, 32'd1);
      check("wb held", {31'd0, held}, 32'd1);
      check("wb mem addr", {26'd0, wr_addr_seen}, 32'h3A);
      check("wb mem data", wr_data_seen, 32'h12345678);
      check("wb d_readdata", bus.d_readdata, exp_d_rd);
      drive(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 32'h0);

      // Watchdog: memory stuck busy
      mem_stuck = 1'b1;
      @(negedge clock);
      drive(1'b1, 6'h0C, 1'b0, 1'b0, 6'h00, 32'h0);
      wait_grant(ok);
      check("wd grant", {31'd0, ok}, 32'd1);
      cnt = 1;
      for (int n = 0; n < 40 && bus.mem_read; n++) begin
         @(negedge clock);
         if (bus.mem_read) cnt++;
      end
      check("wd access cycles", cnt, 32'd8);
      check("wd timeout_err", {31'd0, timeout_err}, 32'd1);
      check("wd released", {31'd0, bus.i_busywait}, 32'd0);
      check("wd strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
      check("wd i_readdata", bus.i_readdata, exp_i_rd);
      drive(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 32'h0);
      mem_stuck = 1'b0;
      repeat (3) @(negedge clock);
      check("wd sticky", {31'd0, timeout_err}, 32'd1);

      // Reset two cycles into a read, then the re-issued read completes
      mem_busy_cycles = 5;
      drive(1'b1, 6'h05, 1'b0, 1'b0, 6'h00, 32'h0);
      wait_grant(ok);
      check("rst grant", {31'd0, ok}, 32'd1);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("rst strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
      check("rst mem_address", {26'd0, bus.mem_address}, 32'd0);
      check("rst i_readdata", bus.i_readdata, 32'd0);
      check("rst d_readdata", bus.d_readdata, 32'd0);
      check("rst timeout_err", {31'd0, timeout_err}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      wait_grant(ok);
      check("rst regrant", {31'd0, ok}, 32'd1);
      check("rst addr", {26'd0, bus.mem_address}, 32'h05);
      wait_done(1'b0, ok);
      check("rst done", {31'd0, ok}, 32'd1);
      check("rst i_readdata after", bus.i_readdata, 32'hDEADBEEF);
      drive(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 32'h0);
      repeat (2) @(negedge clock);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global time limit: simulation still running, expected completion");
      $fatal(1);
   end
endmodule
